// File: rtl/z16_mem_arbiter.sv
// Two-port data-memory arbiter: CPU port 0 has fixed priority, a starvation counter guarantees
// debug port 1 progress, and port 1 may lock the memory for bursts. Reads return one cycle later.
module z16_mem_arbiter #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_p0_req,
  input  logic              i_p0_wen,
  input  logic [ADDR_W-1:0] i_p0_addr,
  input  logic [DATA_W-1:0] i_p0_wdata,
  output logic              o_p0_gnt,
  output logic              o_p0_rvalid,
  output logic [DATA_W-1:0] o_p0_rdata,
  input  logic              i_p1_req,
  input  logic              i_p1_wen,
  input  logic [ADDR_W-1:0] i_p1_addr,
  input  logic [DATA_W-1:0] i_p1_wdata,
  input  logic              i_p1_lock,
  output logic              o_p1_gnt,
  output logic              o_p1_rvalid,
  output logic [DATA_W-1:0] o_p1_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_wen,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_locked
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

  typedef enum logic {StOpen, StLock} state_e;

  state_e            state_q, state_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic              p0_rvalid_q, p0_rvalid_d;
  logic              p1_rvalid_q, p1_rvalid_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
  logic              p0_gnt, p1_gnt;

  // Grant decode; reset suppresses all grants so no access reaches memory during reset.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!i_rst) begin
      if (state_q == StLock) begin
        if (i_p1_req) begin
          p1_gnt = 1'b1;
        end else begin
          p0_gnt = i_p0_req;
        end
      end else if (i_p1_req && (wait_q == WaitMax)) begin
        p1_gnt = 1'b1;
      end else if (i_p0_req) begin
        p0_gnt = 1'b1;
      end else begin
        p1_gnt = i_p1_req;
      end
    end
  end

  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_wen   = 1'b0;
    if (p0_gnt) begin
      o_mem_addr  = i_p0_addr;
      o_mem_wdata = i_p0_wdata;
      o_mem_wen   = i_p0_wen;
    end else if (p1_gnt) begin
      o_mem_addr  = i_p1_addr;
      o_mem_wdata = i_p1_wdata;
      o_mem_wen   = i_p1_wen;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    p0_rvalid_d = p0_gnt && !i_p0_wen;
    p1_rvalid_d = p1_gnt && !i_p1_wen;
    p0_rdata_d  = p0_rvalid_d ? i_mem_rdata : p0_rdata_q;
    p1_rdata_d  = p1_rvalid_d ? i_mem_rdata : p1_rdata_q;

    if (i_p1_req && !p1_gnt) begin
      wait_d = (wait_q == WaitMax) ? wait_q : wait_q + WaitW'(1);
    end

    unique case (state_q)
      StOpen: if (p1_gnt && i_p1_lock) state_d = StLock;
      StLock: if (!i_p1_lock || !i_p1_req) state_d = StOpen;
      default: state_d = StOpen;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StOpen;
      wait_q      <= '0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
    end
  end

  assign o_p0_gnt    = p0_gnt;
  assign o_p1_gnt    = p1_gnt;
  assign o_p0_rvalid = p0_rvalid_q;
  assign o_p1_rvalid = p1_rvalid_q;
  assign o_p0_rdata  = p0_rdata_q;
  assign o_p1_rdata  = p1_rdata_q;
  assign o_locked    = (state_q == StLock);

endmodule

// File: tb/tb_z16_mem_arbiter.sv
// Self-checking bench for z16_mem_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural arbiter/memory model.
module tb_z16_mem_arbiter;

  localparam int MaxWait = 4;

  logic        i_clk, i_rst;
  logic        i_p0_req, i_p0_wen, i_p1_req, i_p1_wen, i_p1_lock;
  logic [15:0] i_p0_addr, i_p0_wdata, i_p1_addr, i_p1_wdata;
  logic        o_p0_gnt, o_p0_rvalid, o_p1_gnt, o_p1_rvalid, o_mem_wen, o_locked;
  logic [15:0] o_p0_rdata, o_p1_rdata, o_mem_addr, o_mem_wdata, i_mem_rdata;

  logic [15:0] mem [256];
  assign i_mem_rdata = mem[o_mem_addr[7:0]];

  z16_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(MaxWait)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_p0_req(i_p0_req), .i_p0_wen(i_p0_wen), .i_p0_addr(i_p0_addr), .i_p0_wdata(i_p0_wdata),
    .o_p0_gnt(o_p0_gnt), .o_p0_rvalid(o_p0_rvalid), .o_p0_rdata(o_p0_rdata),
    .i_p1_req(i_p1_req), .i_p1_wen(i_p1_wen), .i_p1_addr(i_p1_addr), .i_p1_wdata(i_p1_wdata),
    .i_p1_lock(i_p1_lock),
    .o_p1_gnt(o_p1_gnt), .o_p1_rvalid(o_p1_rvalid), .o_p1_rdata(o_p1_rdata),
    .o_mem_addr(o_mem_addr), .o_mem_wen(o_mem_wen), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .o_locked(o_locked)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  bit          m_valid = 0;
  bit          m_lock;
  int          m_wait;
  bit          m_rv0, m_rv1;
  logic [15:0] m_rd0, m_rd1;
  logic [15:0] m_mem [256];

  logic        last_g0, last_g1, last_wen;
  logic [15:0] last_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle with the currently driven inputs: compare at negedge, advance model.
  task automatic cycle();
    bit e_g0, e_g1, e_wen;
    logic [15:0] e_addr, e_wd;
    @(negedge i_clk);
    e_g0 = 0;
    e_g1 = 0;
    if (!i_rst) begin
      if (m_lock) begin
        if (i_p1_req) e_g1 = 1;
        else e_g0 = i_p0_req;
      end else if (i_p1_req && m_wait == MaxWait) e_g1 = 1;
      else if (i_p0_req) e_g0 = 1;
      else e_g1 = i_p1_req;
    end
    e_addr = e_g0 ? i_p0_addr  : e_g1 ? i_p1_addr  : 16'h0;
    e_wd   = e_g0 ? i_p0_wdata : e_g1 ? i_p1_wdata : 16'h0;
    e_wen  = e_g0 ? i_p0_wen   : e_g1 ? i_p1_wen   : 1'b0;
    if (m_valid || i_rst) begin
      chk("p0_gnt", 32'(o_p0_gnt), 32'(e_g0));
      chk("p1_gnt", 32'(o_p1_gnt), 32'(e_g1));
      chk("mem_addr", 32'(o_mem_addr), 32'(e_addr));
      chk("mem_wen", 32'(o_mem_wen), 32'(e_wen));
      chk("mem_wdata", 32'(o_mem_wdata), 32'(e_wd));
    end
    if (m_valid) begin
      chk("locked", 32'(o_locked), 32'(m_lock));
      chk("p0_rvalid", 32'(o_p0_rvalid), 32'(m_rv0));
      chk("p1_rvalid", 32'(o_p1_rvalid), 32'(m_rv1));
      chk("p0_rdata", 32'(o_p0_rdata), 32'(m_rd0));
      chk("p1_rdata", 32'(o_p1_rdata), 32'(m_rd1));
    end
    last_g0   = o_p0_gnt;
    last_g1   = o_p1_gnt;
    last_wen  = o_mem_wen;
    last_addr = o_mem_addr;
    if (o_mem_wen) mem[o_mem_addr[7:0]] = o_mem_wdata;
    if (i_rst) begin
      m_valid = 1;
      m_lock  = 0;
      m_wait  = 0;
      m_rv0   = 0;
      m_rv1   = 0;
      m_rd0   = 0;
      m_rd1   = 0;
    end else begin
      m_rv0 = e_g0 && !i_p0_wen;
      m_rv1 = e_g1 && !i_p1_wen;
      if (m_rv0) m_rd0 = m_mem[i_p0_addr[7:0]];
      if (m_rv1) m_rd1 = m_mem[i_p1_addr[7:0]];
      if (e_g0 && i_p0_wen) m_mem[i_p0_addr[7:0]] = i_p0_wdata;
      if (e_g1 && i_p1_wen) m_mem[i_p1_addr[7:0]] = i_p1_wdata;
      m_wait = (i_p1_req && !e_g1) ? ((m_wait < MaxWait) ? m_wait + 1 : MaxWait) : 0;
      m_lock = m_lock ? (i_p1_lock && i_p1_req) : (e_g1 && i_p1_lock);
    end
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    bit [5:0] pat0, pat1;
    int cnt, first_at;
    bit burst_ok;
    bit any_rv;
    for (int i = 0; i < 256; i++) begin
      mem[i]   = 16'h0;
      m_mem[i] = 16'h0;
    end
    i_rst = 1; i_p0_req = 1; i_p0_wen = 1; i_p0_addr = 16'h0004; i_p0_wdata = 16'h1111;
    i_p1_req = 1; i_p1_wen = 1; i_p1_addr = 16'h0006; i_p1_wdata = 16'h2222; i_p1_lock = 1;
    @(posedge i_clk);
    #1;

    // Reset held two cycles with both ports requesting
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("rst_gnts", {30'h0, last_g0, last_g1}, 32'h0);
      chk("rst_wen", 32'(last_wen), 32'h0);
    end
    chk("rst_rvalid", {30'h0, o_p0_rvalid, o_p1_rvalid}, 32'h0);
    chk("rst_locked", 32'(o_locked), 32'h0);

    // p0 write then read back
    i_rst = 0; i_p1_req = 0; i_p1_lock = 0;
    i_p0_req = 1; i_p0_wen = 1; i_p0_addr = 16'h0010; i_p0_wdata = 16'hBEEF;
    cycle();
    chk("wr_gnt", {30'h0, last_g0, last_wen}, 32'h3);
    i_p0_wen = 0;
    cycle();
    chk("rd_gnt", 32'(last_g0), 32'h1);
    chk("rd_data", {15'h0, o_p0_rvalid, o_p0_rdata}, {15'h0, 1'b1, 16'hBEEF});
    chk("rd_p1_quiet", 32'(o_p1_rvalid), 32'h0);
    i_p0_req = 0;
    cycle();

    // Both ports saturating: p1 wins only once r_wait reaches MaxWait
    i_p0_req = 1; i_p0_wen = 0; i_p0_addr = 16'h0000;
    i_p1_req = 1; i_p1_wen = 0; i_p1_addr = 16'h0002;
    for (int i = 0; i < 6; i++) begin
      cycle();
      pat0[i] = last_g0;
      pat1[i] = last_g1;
    end
    chk("starve_p0", 32'(pat0), 32'h2F);
    chk("starve_p1", 32'(pat1), 32'h10);
    i_p0_req = 0; i_p1_req = 0;
    cycle();

    // p1 locked burst 0x20..0x26 against a persistent p0 request
    i_p0_req = 1; i_p1_req = 1; i_p1_lock = 1; i_p1_addr = 16'h0020;
    cnt = 0; first_at = -1; burst_ok = 1;
    for (int i = 0; i < 20 && cnt < 4; i++) begin
      cycle();
      if (cnt > 0 && !last_g1) burst_ok = 0;
      if (last_g1) begin
        if (cnt == 0) first_at = i;
        cnt++;
        i_p1_addr = i_p1_addr + 16'h2;
        if (cnt == 1) chk("lock_set", 32'(o_locked), 32'h1);
      end
    end
    chk("burst_cnt", 32'(cnt), 32'h4);
    chk("burst_first", 32'(first_at), 32'h4);
    chk("burst_back2back", 32'(burst_ok), 32'h1);
    i_p1_req = 0; i_p1_lock = 0;
    cycle();
    chk("post_lock_p0", 32'(last_g0), 32'h1);
    i_p0_req = 0;
    cycle();

    // Reset in the middle of a lock with a read pending
    i_p1_req = 1; i_p1_lock = 1; i_p1_wen = 0; i_p1_addr = 16'h0010;
    cycle();
    chk("ml_state", {15'h0, o_locked, o_p1_rdata}, {15'h0, 1'b1, 16'hBEEF});
    i_rst = 1;
    cycle();
    chk("ml_after", {14'h0, o_locked, o_p1_rvalid, o_p1_rdata}, 32'h0);
    i_rst = 0; i_p1_req = 0; i_p1_lock = 0;

    // Idle bus
    any_rv = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (last_addr != 0 || last_wen || o_p0_rvalid || o_p1_rvalid) any_rv = 1;
    end
    chk("idle_quiet", 32'(any_rv), 32'h0);

    // Randomized traffic; ungranted requesters hold their request stable
    for (int i = 0; i < 800; i++) begin
      if (!(i_p0_req && !last_g0) || i_rst) begin
        i_p0_req   = ($urandom % 4) != 0;
        i_p0_wen   = $urandom % 2;
        i_p0_addr  = {4'($urandom), 8'h00, 4'($urandom)};
        i_p0_wdata = 16'($urandom);
      end
      if (!(i_p1_req && !last_g1) || i_rst) begin
        i_p1_req   = ($urandom % 3) != 0;
        i_p1_wen   = $urandom % 2;
        i_p1_addr  = {4'($urandom), 8'h00, 4'($urandom)};
        i_p1_wdata = 16'($urandom);
      end
      i_p1_lock = ($urandom % 3) != 0;
      i_rst     = ($urandom % 64) == 0;
      cycle();
      n_tests++;
      if (last_g0 && last_g1) begin
        n_fail++;
        $display("FAIL dual_grant: both grants high at %0t", $time);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
